// File: rtl/drain_out_buffer.sv
// Purpose: parallel-load, byte-serial drain buffer between the edge-detection
//          result stage and the memory write port; sequential write addresses.
// Latency: 1 cycle from accepted load to first write_enable; 1 byte per acked write.
// Backpressure: write_ack low holds write_data/write_addr stable; load_ready low
//               while a block is in flight, so loads are refused until idle.
//
// Ports:
//   clk, n_rst          rising-edge clock, asynchronous active-low reset
//   load_enable/_data   capture NUM_BYTES bytes (byte [0] in bits [7:0] goes out first)
//   load_ready          load will be accepted this cycle (IDLE and empty)
//   buffer_clear        synchronous flush of contents and state (address kept)
//   addr_set/addr_in    preload the write address counter (IDLE/DONE only)
//   write_enable/_data/_addr, write_ack   memory write handshake
//   buffer_full/_empty  decoded from the byte count
//   drain_done          one-cycle pulse after the last byte is acked
module drain_out_buffer #(
  parameter int NUM_BYTES = 12,
  parameter int ADDR_W    = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load_enable,
  input  logic [NUM_BYTES*8-1:0] load_data,
  output logic                   load_ready,
  input  logic                   buffer_clear,
  input  logic                   addr_set,
  input  logic [ADDR_W-1:0]      addr_in,
  output logic                   write_enable,
  output logic [7:0]             write_data,
  output logic [ADDR_W-1:0]      write_addr,
  input  logic                   write_ack,
  output logic                   buffer_full,
  output logic                   buffer_empty,
  output logic                   drain_done
);

  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    count_q;
  logic [7:0]          buf_q [NUM_BYTES];
  logic [ADDR_W-1:0]   addr_q;

  logic                do_load;
  logic                do_ack;
  logic                do_addr_set;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes. buffer_clear wins over load and ack;
  // addr_set is independent of the clear since the address is never flushed.
  always_comb begin
    state_d     = state_q;
    do_load     = 1'b0;
    do_ack      = 1'b0;
    do_addr_set = addr_set && ((state_q == IDLE) || (state_q == DONE));
    if (buffer_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_enable && load_ready) begin
            do_load = 1'b1;
            state_d = SEND;
          end
        end
        SEND: begin
          if (write_ack) begin
            do_ack = 1'b1;
            if (count_q == CNT_W'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Byte store, count and address counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      addr_q  <= '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      if (buffer_clear) begin
        count_q <= '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
          buf_q[i] <= 8'h00;
        end
      end else if (do_load) begin
        count_q <= CNT_W'(NUM_BYTES);
        for (int i = 0; i < NUM_BYTES; i++) begin
          buf_q[i] <= load_data[i*8 +: 8];
        end
      end else if (do_ack) begin
        // Shift toward slot 0 so the next byte is always presented from buf_q[0]
        count_q <= count_q - CNT_W'(1);
        for (int i = 0; i < NUM_BYTES - 1; i++) begin
          buf_q[i] <= buf_q[i+1];
        end
        buf_q[NUM_BYTES-1] <= 8'h00;
      end

      // Address wraps naturally modulo 2^ADDR_W
      if (do_addr_set) begin
        addr_q <= addr_in;
      end else if (do_ack) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // All outputs decode registered state, so they are stable through an ack stall
  assign buffer_empty = (count_q == '0);
  assign buffer_full  = (count_q == CNT_W'(NUM_BYTES));
  assign load_ready   = (state_q == IDLE) && buffer_empty;
  assign write_enable = (state_q == SEND);
  assign write_data   = buf_q[0];
  assign write_addr   = addr_q;
  assign drain_done   = (state_q == DONE);

endmodule

// File: tb/tb_drain_out_buffer.sv
// Purpose: directed self-checking bench for drain_out_buffer (12-byte and 4-byte builds).
// Latency: checks first write one cycle after load and back-to-back bytes under ack.
// Backpressure: exercises ack stalls, refused loads while busy, clear and async reset.
module tb_drain_out_buffer;

  logic        tb_clk;
  logic        n_rst;

  // 12-byte instance
  logic        load_enable;
  logic [95:0] load_data;
  logic        load_ready;
  logic        buffer_clear;
  logic        addr_set;
  logic [15:0] addr_in;
  logic        write_enable;
  logic [7:0]  write_data;
  logic [15:0] write_addr;
  logic        write_ack;
  logic        buffer_full;
  logic        buffer_empty;
  logic        drain_done;

  // 4-byte instance for the address wrap case
  logic        b_load_enable;
  logic [31:0] b_load_data;
  logic        b_load_ready;
  logic        b_buffer_clear;
  logic        b_addr_set;
  logic [15:0] b_addr_in;
  logic        b_write_enable;
  logic [7:0]  b_write_data;
  logic [15:0] b_write_addr;
  logic        b_write_ack;
  logic        b_buffer_full;
  logic        b_buffer_empty;
  logic        b_drain_done;

  int tests  = 0;
  int failed = 0;

  logic [7:0] pat [12] = '{8'h2A, 8'h32, 8'h64, 8'h85, 8'h45, 8'hE1,
                           8'h76, 8'h40, 8'h23, 8'hA8, 8'h4F, 8'h9D};
  logic [95:0] pat_vec;
  logic [95:0] alt_vec;
  logic [95:0] c_vec;

  drain_out_buffer #(.NUM_BYTES(12), .ADDR_W(16)) dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .load_enable  (load_enable),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .buffer_clear (buffer_clear),
    .addr_set     (addr_set),
    .addr_in      (addr_in),
    .write_enable (write_enable),
    .write_data   (write_data),
    .write_addr   (write_addr),
    .write_ack    (write_ack),
    .buffer_full  (buffer_full),
    .buffer_empty (buffer_empty),
    .drain_done   (drain_done)
  );

  drain_out_buffer #(.NUM_BYTES(4), .ADDR_W(16)) dut_b (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .load_enable  (b_load_enable),
    .load_data    (b_load_data),
    .load_ready   (b_load_ready),
    .buffer_clear (b_buffer_clear),
    .addr_set     (b_addr_set),
    .addr_in      (b_addr_in),
    .write_enable (b_write_enable),
    .write_data   (b_write_data),
    .write_addr   (b_write_addr),
    .write_ack    (b_write_ack),
    .buffer_full  (b_buffer_full),
    .buffer_empty (b_buffer_empty),
    .drain_done   (b_drain_done)
  );

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      pat_vec[i*8 +: 8] = pat[i];
      alt_vec[i*8 +: 8] = 8'hEE;
      c_vec[i*8 +: 8]   = 8'hC0 + 8'(i);
    end

    n_rst          = 1'b0;
    load_enable    = 1'b0;
    load_data      = '0;
    buffer_clear   = 1'b0;
    addr_set       = 1'b0;
    addr_in        = '0;
    write_ack      = 1'b0;
    b_load_enable  = 1'b0;
    b_load_data    = '0;
    b_buffer_clear = 1'b0;
    b_addr_set     = 1'b0;
    b_addr_in      = '0;
    b_write_ack    = 1'b0;

    // ---- reset values ----
    #2;
    chk("rst write_enable", 32'(write_enable), 0);
    chk("rst write_data",   32'(write_data),   0);
    chk("rst write_addr",   32'(write_addr),   0);
    chk("rst drain_done",   32'(drain_done),   0);
    chk("rst buffer_empty", 32'(buffer_empty), 1);
    chk("rst buffer_full",  32'(buffer_full),  0);
    chk("rst load_ready",   32'(load_ready),   1);
    step();
    step();
    n_rst = 1'b1;

    // ---- basic drain, ack held high from before the load ----
    addr_set    = 1'b1;
    addr_in     = 16'h0100;
    load_enable = 1'b1;
    load_data   = pat_vec;
    write_ack   = 1'b1;
    step();
    addr_set    = 1'b0;
    load_enable = 1'b0;
    chk("t1 load_ready busy", 32'(load_ready), 0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t1 we[%0d]", i),   32'(write_enable), 1);
      chk($sformatf("t1 data[%0d]", i), 32'(write_data),   32'(pat[i]));
      chk($sformatf("t1 addr[%0d]", i), 32'(write_addr),   'h0100 + i);
      chk($sformatf("t1 full[%0d]", i), 32'(buffer_full),  (i == 0) ? 1 : 0);
      chk($sformatf("t1 done[%0d]", i), 32'(drain_done),   0);
      step();
    end
    chk("t1 done pulse",   32'(drain_done),   1);
    chk("t1 we off",       32'(write_enable), 0);
    chk("t1 empty",        32'(buffer_empty), 1);
    step();
    chk("t1 done cleared", 32'(drain_done),   0);
    chk("t1 ready again",  32'(load_ready),   1);

    // ---- ack stall on 2nd byte, plus refused load and addr_set while busy ----
    write_ack   = 1'b0;
    addr_set    = 1'b1;
    addr_in     = 16'h0100;
    load_enable = 1'b1;
    load_data   = pat_vec;
    step();
    addr_set    = 1'b0;
    load_enable = 1'b0;
    write_ack   = 1'b1;
    step();
    write_ack   = 1'b0;
    load_enable = 1'b1;
    load_data   = alt_vec;
    addr_set    = 1'b1;
    addr_in     = 16'h0500;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t2 stall data[%0d]", k),  32'(write_data),   'h32);
      chk($sformatf("t2 stall addr[%0d]", k),  32'(write_addr),   'h0101);
      chk($sformatf("t2 stall we[%0d]", k),    32'(write_enable), 1);
      chk($sformatf("t2 stall ready[%0d]", k), 32'(load_ready),   0);
      chk($sformatf("t2 stall full[%0d]", k),  32'(buffer_full),  0);
      chk($sformatf("t2 stall empty[%0d]", k), 32'(buffer_empty), 0);
    end
    load_enable = 1'b0;
    addr_set    = 1'b0;
    write_ack   = 1'b1;
    for (int i = 1; i < 12; i++) begin
      chk($sformatf("t2 data[%0d]", i), 32'(write_data), 32'(pat[i]));
      chk($sformatf("t2 addr[%0d]", i), 32'(write_addr), 'h0100 + i);
      step();
    end
    chk("t2 done pulse", 32'(drain_done), 1);
    step();

    // ---- mid-drain clear together with an ack ----
    addr_set    = 1'b1;
    addr_in     = 16'h0100;
    load_enable = 1'b1;
    load_data   = pat_vec;
    step();
    addr_set    = 1'b0;
    load_enable = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t3 pre-clear addr", 32'(write_addr), 'h0105);
    chk("t3 pre-clear data", 32'(write_data), 'hE1);
    buffer_clear = 1'b1;
    step();
    buffer_clear = 1'b0;
    chk("t3 clr we",    32'(write_enable), 0);
    chk("t3 clr empty", 32'(buffer_empty), 1);
    chk("t3 clr done",  32'(drain_done),   0);
    chk("t3 clr addr",  32'(write_addr),   'h0105);
    chk("t3 clr ready", 32'(load_ready),   1);
    step();
    chk("t3 no done later", 32'(drain_done), 0);
    load_enable = 1'b1;
    load_data   = c_vec;
    step();
    load_enable = 1'b0;
    chk("t3 reload addr", 32'(write_addr),   'h0105);
    chk("t3 reload data", 32'(write_data),   'hC0);
    chk("t3 reload we",   32'(write_enable), 1);
    step();
    step();
    chk("t3 third addr", 32'(write_addr), 'h0107);
    chk("t3 third data", 32'(write_data), 'hC2);

    // ---- async reset between edges during SEND ----
    #2;
    n_rst = 1'b0;
    #1;
    chk("t4 rst we",    32'(write_enable), 0);
    chk("t4 rst empty", 32'(buffer_empty), 1);
    chk("t4 rst addr",  32'(write_addr),   0);
    chk("t4 rst data",  32'(write_data),   0);
    chk("t4 rst ready", 32'(load_ready),   1);
    write_ack = 1'b0;
    step();
    n_rst = 1'b1;
    step();
    chk("t4 stays idle", 32'(write_enable), 0);

    // ---- address wrap on the 4-byte build ----
    b_addr_set    = 1'b1;
    b_addr_in     = 16'hFFFE;
    b_load_enable = 1'b1;
    b_load_data   = 32'h44332211;
    b_write_ack   = 1'b1;
    step();
    b_addr_set    = 1'b0;
    b_load_enable = 1'b0;
    chk("t5 full",   32'(b_buffer_full), 1);
    chk("t5 addr0",  32'(b_write_addr), 'hFFFE);
    chk("t5 data0",  32'(b_write_data), 'h11);
    step();
    chk("t5 addr1",  32'(b_write_addr), 'hFFFF);
    chk("t5 data1",  32'(b_write_data), 'h22);
    step();
    chk("t5 addr2",  32'(b_write_addr), 'h0000);
    chk("t5 data2",  32'(b_write_data), 'h33);
    step();
    chk("t5 addr3",  32'(b_write_addr), 'h0001);
    chk("t5 data3",  32'(b_write_data), 'h44);
    step();
    chk("t5 done",   32'(b_drain_done), 1);
    chk("t5 empty",  32'(b_buffer_empty), 1);
    chk("t5 addr_end", 32'(b_write_addr), 'h0002);
    b_write_ack = 1'b0;
    step();
    chk("t5 ready",  32'(b_load_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
